// File: rtl/memory_arbiter.sv
// Shares one RAM port between an instruction and a data requester: data wins unless the instruction side has waited STARVE_MAX grants.
// Strobe 1 cycle after grant, hit 1 cycle after ramready, re-arbitration on the cycle after the hit; requests are held until their hit.
module memory_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IACC,
    ST_DACC,
    ST_IDONE,
    ST_DDONE
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_starve;
  logic          w_dreq;
  logic          w_dgrant;

  assign w_dreq   = dREN | dWEN;
  assign w_dgrant = w_dreq & ~(iREN & (r_starve == SMAX));

  // The RAM strobe/address/data registers double as the latched request:
  // they are loaded on a grant and cleared when the access completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_dgrant) begin
            r_state  <= ST_DACC;
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
            if (iREN) begin
              r_starve <= (r_starve == SMAX) ? SMAX : r_starve + 1'b1;
            end else begin
              r_starve <= '0;
            end
          end else if (iREN) begin
            r_state  <= ST_IACC;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            ramaddr  <= iaddr;
            ramstore <= '0;
            r_starve <= '0;
          end
        end
        ST_IACC: begin
          if (ramready) begin
            r_state  <= ST_IDONE;
            iload    <= ramload;
            ihit     <= 1'b1;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
          end
        end
        ST_DACC: begin
          if (ramready) begin
            r_state <= ST_DDONE;
            if (!ramWEN) begin
              dload <= ramload;
            end
            dhit     <= 1'b1;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
          end
        end
        ST_IDONE: r_state <= ST_IDLE;
        ST_DDONE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_memory_arbiter;

  localparam int SMAX = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic        ramready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    cyc(); cyc();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h40; daddr = 32'h200; dstore = 32'h0; ramready = 1'b0;
    cyc(); cyc();
    n_tests++;
    if ({ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, iload, dload} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got hits=%b%b strobes=%b%b addr=%h store=%h iload=%h dload=%h exp all 0",
               ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, iload, dload);
    end
    RST = 1'b0;
    cyc();
    n_tests++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h200) begin
      n_fail++;
      $display("FAIL reset_first_grant got ren=%b wen=%b addr=%h exp ren=1 wen=0 addr=00000200", ramREN, ramWEN, ramaddr);
    end
    ramready = 1'b1; ramload = 32'h0BADF00D;
    cyc();
    n_tests++;
    if (dhit !== 1'b1 || dload !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL reset_first_hit got dhit=%b dload=%h exp dhit=1 dload=0badf00d", dhit, dload);
    end
  endtask

  task automatic test_ifetch();
    do_reset();
    iREN = 1'b1; iaddr = 32'h40; ramready = 1'b0; ramload = 32'h0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_tests++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
        n_fail++;
        $display("FAIL ifetch_acc%0d got ren=%b wen=%b addr=%h ihit=%b exp ren=1 wen=0 addr=00000040 ihit=0",
                 k, ramREN, ramWEN, ramaddr, ihit);
      end
      if (k == 2) begin
        ramready = 1'b1; ramload = 32'hDEADBEEF;
      end
    end
    cyc();
    n_tests++;
    if (ihit !== 1'b1 || iload !== 32'hDEADBEEF || ramREN !== 1'b0 || dhit !== 1'b0) begin
      n_fail++;
      $display("FAIL ifetch_hit got ihit=%b dhit=%b iload=%h ren=%b exp ihit=1 dhit=0 iload=deadbeef ren=0",
               ihit, dhit, iload, ramREN);
    end
    iREN = 1'b0; ramready = 1'b0;
    cyc();
    n_tests++;
    if (ihit !== 1'b0 || ramREN !== 1'b0 || iload !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ifetch_after got ihit=%b ren=%b iload=%h exp ihit=0 ren=0 iload=deadbeef", ihit, ramREN, iload);
    end
  endtask

  task automatic test_collision();
    do_reset();
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678; ramready = 1'b1;
    cyc();
    n_tests++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'h12345678) begin
      n_fail++;
      $display("FAIL collision_write got wen=%b ren=%b addr=%h store=%h exp wen=1 ren=0 addr=00000100 store=12345678",
               ramWEN, ramREN, ramaddr, ramstore);
    end
    cyc();
    n_tests++;
    if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h0) begin
      n_fail++;
      $display("FAIL collision_dhit got dhit=%b ihit=%b dload=%h exp dhit=1 ihit=0 dload=00000000", dhit, ihit, dload);
    end
    dWEN = 1'b0; ramready = 1'b0;
    cyc();
    n_tests++;
    if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
      n_fail++;
      $display("FAIL collision_idle got hits/strobes=%b exp 0000", {ihit, dhit, ramREN, ramWEN});
    end
    cyc();
    n_tests++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin
      n_fail++;
      $display("FAIL collision_iacc got ren=%b addr=%h exp ren=1 addr=00000080", ramREN, ramaddr);
    end
    ramready = 1'b1; ramload = 32'hCAFEF00D;
    cyc();
    n_tests++;
    if (ihit !== 1'b1 || iload !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL collision_ihit got ihit=%b iload=%h exp ihit=1 iload=cafef00d", ihit, iload);
    end
    iREN = 1'b0; ramready = 1'b0;
  endtask

  task automatic test_starvation();
    int  exp_d [6];
    int  got;
    logic prev;
    exp_d = '{1, 1, 0, 1, 1, 0};
    got = 0;
    prev = 1'b0;
    do_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h1000; daddr = 32'h2000; ramready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      cyc();
      if (ramREN && !prev) begin
        n_tests++;
        if (ramaddr !== ((exp_d[got] != 0) ? 32'h2000 : 32'h1000)) begin
          n_fail++;
          $display("FAIL starve_grant%0d got addr=%h exp %s", got, ramaddr, (exp_d[got] != 0) ? "D(00002000)" : "I(00001000)");
        end
        got++;
      end
      prev = ramREN;
    end
    n_tests++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL starve_count got %0d grants exp 6", got);
    end
    iREN = 1'b0; dREN = 1'b0; ramready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    dREN = 1'b1; daddr = 32'h500; ramready = 1'b1; ramload = 32'hAAAA5555;
    cyc(); cyc();
    n_tests++;
    if (dhit !== 1'b1 || dload !== 32'hAAAA5555) begin
      n_fail++;
      $display("FAIL rstmid_preload got dhit=%b dload=%h exp dhit=1 dload=aaaa5555", dhit, dload);
    end
    daddr = 32'h300; ramready = 1'b0;
    cyc(); cyc();
    n_tests++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
      n_fail++;
      $display("FAIL rstmid_dacc got ren=%b addr=%h exp ren=1 addr=00000300", ramREN, ramaddr);
    end
    RST = 1'b1;
    cyc();
    RST = 1'b0; dREN = 1'b0; ramready = 1'b1; ramload = 32'h12;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_tests++;
      if (dhit !== 1'b0 || ramREN !== 1'b0 || ramWEN !== 1'b0 || dload !== 32'h0) begin
        n_fail++;
        $display("FAIL rstmid_after%0d got dhit=%b ren=%b wen=%b dload=%h exp 0 0 0 00000000",
                 k, dhit, ramREN, ramWEN, dload);
      end
    end
    ramready = 1'b0;
  endtask

  task automatic test_dropped_request();
    int nh;
    int ns;
    do_reset();
    dREN = 1'b1; daddr = 32'h400; ramready = 1'b0;
    cyc();
    n_tests++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h400) begin
      n_fail++;
      $display("FAIL drop_dacc got ren=%b addr=%h exp ren=1 addr=00000400", ramREN, ramaddr);
    end
    dREN = 1'b0;
    cyc();
    n_tests++;
    if (ramREN !== 1'b1 || dhit !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_hold got ren=%b dhit=%b exp ren=1 dhit=0", ramREN, dhit);
    end
    ramready = 1'b1; ramload = 32'h77;
    cyc();
    n_tests++;
    if (dload !== 32'h77) begin
      n_fail++;
      $display("FAIL drop_dload got %h exp 00000077", dload);
    end
    nh = int'(dhit);
    ns = 0;
    ramready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      nh += int'(dhit);
      ns += int'(ramREN | ramWEN);
    end
    n_tests++;
    if (nh != 1 || ns != 0) begin
      n_fail++;
      $display("FAIL drop_once got dhits=%0d strobe_cycles=%0d exp 1 and 0", nh, ns);
    end
  endtask

  // Transaction-level model: phase 0 = waiting for a grant, 1 = RAM access owned by m_own_d,
  // 2 = completion cycle. Arbitration follows the data-first rule with a starvation budget.
  task automatic test_random();
    int          ph;
    int          m_starve;
    logic        m_own_d, m_wr;
    logic [31:0] m_addr, m_store, m_iload, m_dload;
    logic        i_pend, d_pend, rst;
    int          d_op;
    logic [3:0]  exp_hs;
    logic [31:0] exp_addr, exp_store;
    do_reset();
    ph = 0; m_starve = 0; m_own_d = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
    i_pend = 1'b0; d_pend = 1'b0; d_op = 0;
    for (int c = 0; c < 3000; c++) begin
      exp_hs    = {ph == 2 && !m_own_d, ph == 2 && m_own_d, ph == 1 && !m_wr, ph == 1 && m_wr};
      exp_addr  = (ph == 1) ? m_addr : 32'h0;
      exp_store = (ph == 1) ? m_store : 32'h0;
      n_tests++;
      if ({ihit, dhit, ramREN, ramWEN} !== exp_hs) begin
        n_fail++;
        $display("FAIL rnd_hits_strobes c=%0d got=%b exp=%b", c, {ihit, dhit, ramREN, ramWEN}, exp_hs);
      end
      n_tests++;
      if (ramaddr !== exp_addr || ramstore !== exp_store) begin
        n_fail++;
        $display("FAIL rnd_ram_bus c=%0d got addr=%h store=%h exp addr=%h store=%h", c, ramaddr, ramstore, exp_addr, exp_store);
      end
      n_tests++;
      if (iload !== m_iload || dload !== m_dload) begin
        n_fail++;
        $display("FAIL rnd_loads c=%0d got iload=%h dload=%h exp iload=%h dload=%h", c, iload, dload, m_iload, m_dload);
      end

      // Requesters: finish on their hit, occasionally withdraw, start new requests at random.
      if (ph == 2 && !m_own_d) i_pend = 1'b0;
      if (ph == 2 && m_own_d)  d_pend = 1'b0;
      if (i_pend && $urandom_range(0, 39) == 0) i_pend = 1'b0;
      if (d_pend && $urandom_range(0, 39) == 0) d_pend = 1'b0;
      if (!i_pend && $urandom_range(0, 3) == 0) i_pend = 1'b1;
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        d_op = int'($urandom_range(0, 2));
      end
      rst      = ($urandom_range(0, 99) == 0);
      RST      = rst;
      iREN     = i_pend;
      dREN     = d_pend && (d_op != 1);
      dWEN     = d_pend && (d_op != 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramready = ($urandom_range(0, 2) == 0);

      if (rst) begin
        ph = 0; m_starve = 0; m_own_d = 1'b0; m_wr = 1'b0;
        m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
      end else if (ph == 0) begin
        if ((dREN || dWEN) && !(iREN && m_starve == SMAX)) begin
          ph = 1; m_own_d = 1'b1; m_wr = dWEN; m_addr = daddr; m_store = dstore;
          m_starve = iREN ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end else if (iREN) begin
          ph = 1; m_own_d = 1'b0; m_wr = 1'b0; m_addr = iaddr; m_store = '0;
          m_starve = 0;
        end
      end else if (ph == 1) begin
        if (ramready) begin
          ph = 2;
          if (!m_own_d)   m_iload = ramload;
          else if (!m_wr) m_dload = ramload;
        end
      end else begin
        ph = 0;
      end
      cyc();
    end
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_collision();
    test_starvation();
    test_reset_mid_access();
    test_dropped_request();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
